// File: rtl/hazard_pkg.sv
// Shared constants, state encoding and dependency-match helper for the hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // $0 is hardwired, so it never creates a dependency.
  function automatic logic dep_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst,
                                     input logic             en);
    return en && (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Occupancy timer for the multi-cycle mult/div unit: busy for MD_CYCLES cycles after a launch.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic CLK,
  input  logic CLR,
  input  logic md_start_e,
  output logic md_busy
);

  localparam int unsigned CNT_W = $clog2(MD_CYCLES);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      md_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_busy <= (state_d == BUSY);
    end
  end

  // A launch while already busy is ignored; the count is never reloaded.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start_e) begin
          cnt_d   = CNT_W'(MD_CYCLES - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush and operand forwarding controls.
// Build option: define HAZARD_FWD_EN to enable forwarding; otherwise dependencies stall.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] write_reg_e,
  input  logic [REG_W-1:0] write_reg_m,
  input  logic [REG_W-1:0] write_reg_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem_to_reg_e,
  input  logic             mem_to_reg_m,
  input  logic             branch_d,
  input  logic             pc_src_d,
  input  logic             md_issue_d,
  input  logic             md_use_d,
  input  logic             md_start_e,
  output logic             hold_f,
  output logic             hold_d,
  output logic             bubble_d,
  output logic             bubble_e,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             md_busy
);

  logic lw_stall, dep_stall, md_stall, stall;

  md_busy_timer #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_busy_timer (
    .CLK        (CLK),
    .CLR        (CLR),
    .md_start_e (md_start_e),
    .md_busy    (md_busy)
  );

  assign lw_stall = dep_match(rs_d, write_reg_e, mem_to_reg_e) |
                    dep_match(rt_d, write_reg_e, mem_to_reg_e);

  assign md_stall = (md_use_d | md_issue_d) & (md_busy | md_start_e);

`ifdef HAZARD_FWD_EN
  // M-stage result wins over W-stage result for the same register.
  always_comb begin
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    if (dep_match(rs_e, write_reg_m, reg_write_m))      fwd_a_e = FWD_MEM;
    else if (dep_match(rs_e, write_reg_w, reg_write_w)) fwd_a_e = FWD_WB;
    if (dep_match(rt_e, write_reg_m, reg_write_m))      fwd_b_e = FWD_MEM;
    else if (dep_match(rt_e, write_reg_w, reg_write_w)) fwd_b_e = FWD_WB;
  end

  assign fwd_a_d = dep_match(rs_d, write_reg_m, reg_write_m);
  assign fwd_b_d = dep_match(rt_d, write_reg_m, reg_write_m);

  // Decode comparator cannot see an E-stage result or a load still in M.
  assign dep_stall = branch_d & (dep_match(rs_d, write_reg_e, reg_write_e)  |
                                 dep_match(rt_d, write_reg_e, reg_write_e)  |
                                 dep_match(rs_d, write_reg_m, mem_to_reg_m) |
                                 dep_match(rt_d, write_reg_m, mem_to_reg_m));
`else
  logic unused_fwd_inputs;

  assign fwd_a_e = FWD_RF;
  assign fwd_b_e = FWD_RF;
  assign fwd_a_d = 1'b0;
  assign fwd_b_d = 1'b0;

  // W-stage writes land in the first half-cycle, so only E and M dependencies stall.
  assign dep_stall = dep_match(rs_d, write_reg_e, reg_write_e) |
                     dep_match(rt_d, write_reg_e, reg_write_e) |
                     dep_match(rs_d, write_reg_m, reg_write_m) |
                     dep_match(rt_d, write_reg_m, reg_write_m);

  assign unused_fwd_inputs = ^{rs_e, rt_e, write_reg_w, reg_write_w, branch_d, mem_to_reg_m};
`endif

  assign stall    = lw_stall | dep_stall | md_stall;
  assign hold_f   = stall;
  assign hold_d   = stall;
  assign bubble_e = stall;
  assign bubble_d = pc_src_d & ~stall;

endmodule
